pci_master_fsm: RTL

Parametrised PCI initiator bus-cycle controller, successor to the single-mode PCI state machine. It runs the full initiator side of a PCI transaction:
- requests the bus and waits for grant
- drives `frame_n`, `irdy_n` and `req_n`
- counts data beats up to a programmable burst length
- handles target retry/disconnect (`stop_n`) and master abort (DEVSEL timeout)

It sits between the local command interface and the PCI pad logic, and supplies the `xfer` strobe used by the AD datapath.

---
 rtl/pci_pkg.sv | 37 +++
 rtl/pci_timer.sv | 27 ++
 rtl/pci_master_fsm.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pci_pkg.sv
// rtl/pci_pkg.sv - shared state/termination encodings and defaults for the PCI initiator
package pci_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_TURN   = 3'd3,
    ST_DATA   = 3'd4,
    ST_LAST   = 3'd5,
    ST_FINISH = 3'd6
  } pci_state_e;

  typedef enum logic [1:0] {
    TERM_DONE  = 2'd0,
    TERM_STOP  = 2'd1,
    TERM_ABORT = 2'd2
  } pci_term_e;

  localparam int MAX_BURST_DEF = 8;
  localparam int DEVSEL_TO_DEF = 5;
  localparam int LAT_TIMER_DEF = 16;

  // Pad levels {req_n, frame_n, irdy_n} held while in a given state.
  function automatic logic [2:0] pci_pins(input pci_state_e s);
    logic [2:0] pins;
    case (s)
      ST_REQ:           pins = 3'b011;
      ST_ADDR, ST_TURN: pins = 3'b101;
      ST_DATA:          pins = 3'b100;
      ST_LAST:          pins = 3'b110;
      default:          pins = 3'b111;
    endcase
    return pins;
  endfunction

endpackage

// File: rtl/pci_timer.sv
// rtl/pci_timer.sv - loadable saturating down-counter with zero flag
module pci_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/pci_master_fsm.sv
// rtl/pci_master_fsm.sv - PCI initiator bus-cycle controller
// Optional latency timer enabled by defining PCI_LAT_TIMER_EN.
module pci_master_fsm
  import pci_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int DEVSEL_TO = DEVSEL_TO_DEF,
  parameter int LAT_TIMER = LAT_TIMER_DEF,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rd_wr,
  input  logic [CNT_W-1:0] req_count,
  input  logic             gnt_n,
  input  logic             trdy_n,
  input  logic             devsel_n,
  input  logic             stop_n,
  output logic             req_n,
  output logic             frame_n,
  output logic             irdy_n,
  output logic [2:0]       state,
  output logic             busy,
  output logic             xfer,
  output logic [CNT_W-1:0] beat_count,
  output logic             done,
  output logic             retry,
  output logic             abort
);

  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam int               DW   = $clog2(DEVSEL_TO + 1);

  pci_state_e       state_q, state_d;
  pci_term_e        cause_q, cause_d;
  logic             req_n_q, frame_n_q, irdy_n_q;
  logic             rd_q, devsel_seen_q;
  logic [CNT_W-1:0] target_q, beat_q;
  logic             done_q, retry_q, abort_q;

  logic             addr_load, dev_zero, abort_cond, lat_expire;
  logic             fin, fin_retry;
  logic [CNT_W-1:0] rem, rem_after;

  assign addr_load = (state_q == ST_REQ) && !gnt_n;

  // Timer is loaded with DEVSEL_TO-1 on entry to ADDR so it reads zero DEVSEL_TO-1 clocks later.
  pci_timer #(.W(DW)) u_devsel_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (addr_load),
    .load_val_i (DW'(DEVSEL_TO - 1)),
    .dec_i      (1'b1),
    .zero_o     (dev_zero)
  );

`ifdef PCI_LAT_TIMER_EN
  localparam int LW = $clog2(LAT_TIMER + 1);
  logic lat_zero;

  pci_timer #(.W(LW)) u_lat_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (addr_load),
    .load_val_i (LW'(LAT_TIMER - 1)),
    .dec_i      ((state_q == ST_ADDR) || (state_q == ST_DATA)),
    .zero_o     (lat_zero)
  );

  assign lat_expire = lat_zero && gnt_n;
`else
  logic lat_unused;
  assign lat_unused = |LAT_TIMER;
  assign lat_expire = 1'b0;
`endif

  assign xfer       = ((state_q == ST_DATA) || (state_q == ST_LAST)) && !irdy_n_q && !trdy_n;
  assign abort_cond = dev_zero && devsel_n && !devsel_seen_q;
  assign rem        = target_q - beat_q;
  assign rem_after  = rem - CNT_W'(xfer);
  assign fin        = (state_q == ST_FINISH);
  assign fin_retry  = (cause_q == TERM_STOP) && (beat_q == '0);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_REQ;
        cause_d = TERM_DONE;
      end
      ST_REQ:  if (!gnt_n) state_d = ST_ADDR;
      ST_ADDR: begin
        if (rd_q)                 state_d = ST_TURN;
        else if (target_q == ONE) state_d = ST_LAST;
        else                      state_d = ST_DATA;
      end
      ST_TURN: state_d = (target_q == ONE) ? ST_LAST : ST_DATA;
      ST_DATA: begin
        if (abort_cond) begin
          state_d = ST_FINISH;
          cause_d = TERM_ABORT;
        end else if (!stop_n) begin
          state_d = ST_LAST;
          cause_d = TERM_STOP;
        end else if (rem_after == '0) begin
          state_d = ST_FINISH;
        end else if (rem_after == ONE || lat_expire) begin
          state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        if (abort_cond) begin
          state_d = ST_FINISH;
          cause_d = TERM_ABORT;
        end else if (xfer || !stop_n) begin
          state_d = ST_FINISH;
          if (!stop_n) cause_d = TERM_STOP;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cause_q       <= TERM_DONE;
      req_n_q       <= 1'b1;
      frame_n_q     <= 1'b1;
      irdy_n_q      <= 1'b1;
      rd_q          <= 1'b0;
      devsel_seen_q <= 1'b0;
      target_q      <= '0;
      beat_q        <= '0;
      done_q        <= 1'b0;
      retry_q       <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q                          <= state_d;
      cause_q                          <= cause_d;
      {req_n_q, frame_n_q, irdy_n_q}   <= pci_pins(state_d);
      abort_q                          <= fin && (cause_q == TERM_ABORT);
      retry_q                          <= fin && fin_retry;
      done_q                           <= fin && (cause_q != TERM_ABORT) && !fin_retry;
      if (state_q == ST_IDLE && start) begin
        rd_q          <= rd_wr;
        beat_q        <= '0;
        devsel_seen_q <= 1'b0;
        if (req_count == '0)       target_q <= ONE;
        else if (req_count > MAXC) target_q <= MAXC;
        else                       target_q <= req_count;
      end else begin
        if (xfer && beat_q != MAXC) beat_q <= beat_q + ONE;
        if (!devsel_n && state_q != ST_IDLE && state_q != ST_REQ) devsel_seen_q <= 1'b1;
      end
    end
  end

  assign req_n      = req_n_q;
  assign frame_n    = frame_n_q;
  assign irdy_n     = irdy_n_q;
  assign state      = state_q;
  assign busy       = (state_q != ST_IDLE);
  assign beat_count = beat_q;
  assign done       = done_q;
  assign retry      = retry_q;
  assign abort      = abort_q;

endmodule
